// File: rtl/encoder_4x2.sv
// MSB-priority 4-to-2 encoder with a registered result.
// Also keeps a saturating count of zero/multi-hot samples.
module encoder_4x2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       d,
    output logic [1:0]       a,
    output logic             valid,
    output logic             multi,
    output logic [1:0]       a_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0]       a_q_d;
    logic             valid_q_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic             bad_code;

    // Highest set bit wins when more than one request is raised.
    always_comb begin
        a = 2'b00;
        priority case (1'b1)
            d[3]:    a = 2'b11;
            d[2]:    a = 2'b10;
            d[1]:    a = 2'b01;
            default: a = 2'b00;
        endcase
    end

    assign valid    = |d;
    assign multi    = ($countones(d) > 1);
    assign bad_code = ~valid | multi;

    always_comb begin
        a_q_d     = a;
        valid_q_d = valid;
        err_cnt_d = err_cnt_q;
        if (bad_code && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= 2'b00;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            a_q       <= a_q_d;
            valid_q   <= valid_q_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_encoder_4x2.sv
// Directed bench for encoder_4x2: vector table plus
// hand-written reset, saturation and latency sequences.
module tb_encoder_4x2;

    typedef struct {
        logic [3:0] d;
        logic [1:0] a;
        logic       valid;
        logic       multi;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [1:0] a;
    logic       valid;
    logic       multi;
    logic [1:0] a_q;
    logic       valid_q;
    logic [7:0] err_cnt;

    int total;
    int passed;
    int exp_cnt;
    vec_t tab [16];

    encoder_4x2 #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .a       (a),
        .valid   (valid),
        .multi   (multi),
        .a_q     (a_q),
        .valid_q (valid_q),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_comb(input string tag, input vec_t v);
        chk({tag, " a"}, {30'd0, a}, {30'd0, v.a});
        chk({tag, " valid"}, {31'd0, valid}, {31'd0, v.valid});
        chk({tag, " multi"}, {31'd0, multi}, {31'd0, v.multi});
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] ea,
                           input logic ev, input int ec);
        chk({tag, " a_q"}, {30'd0, a_q}, {30'd0, ea});
        chk({tag, " valid_q"}, {31'd0, valid_q}, {31'd0, ev});
        chk({tag, " err_cnt"}, {24'd0, err_cnt}, ec);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tab[0]  = '{4'b0000, 2'b00, 1'b0, 1'b0};
        tab[1]  = '{4'b0001, 2'b00, 1'b1, 1'b0};
        tab[2]  = '{4'b0010, 2'b01, 1'b1, 1'b0};
        tab[3]  = '{4'b0011, 2'b01, 1'b1, 1'b1};
        tab[4]  = '{4'b0100, 2'b10, 1'b1, 1'b0};
        tab[5]  = '{4'b0101, 2'b10, 1'b1, 1'b1};
        tab[6]  = '{4'b0110, 2'b10, 1'b1, 1'b1};
        tab[7]  = '{4'b0111, 2'b10, 1'b1, 1'b1};
        tab[8]  = '{4'b1000, 2'b11, 1'b1, 1'b0};
        tab[9]  = '{4'b1001, 2'b11, 1'b1, 1'b1};
        tab[10] = '{4'b1010, 2'b11, 1'b1, 1'b1};
        tab[11] = '{4'b1011, 2'b11, 1'b1, 1'b1};
        tab[12] = '{4'b1100, 2'b11, 1'b1, 1'b1};
        tab[13] = '{4'b1101, 2'b11, 1'b1, 1'b1};
        tab[14] = '{4'b1110, 2'b11, 1'b1, 1'b1};
        tab[15] = '{4'b1111, 2'b11, 1'b1, 1'b1};
        total  = 0;
        passed = 0;

        // reset state, comb path live during reset
        rst_n = 1'b0;
        d = 4'b0000;
        #3;
        chk_reg("rst", 2'b00, 1'b0, 0);
        d = 4'b0100;
        #1;
        chk_comb("rst comb", tab[4]);
        tick();
        tick();
        chk_reg("rst held", 2'b00, 1'b0, 0);

        // zero code
        @(negedge clk);
        rst_n = 1'b1;
        d = 4'b0000;
        #1;
        chk_comb("zero", tab[0]);
        tick();
        chk_reg("zero", 2'b00, 1'b0, 1);
        exp_cnt = 1;

        // one-hot codes leave err_cnt alone
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = 4'b0001 << i;
            #1;
            chk_comb("onehot", tab[1 << i]);
            tick();
            chk_reg("onehot", tab[1 << i].a, 1'b1, exp_cnt);
        end

        // exhaustive sweep with one-cycle lag check
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = tab[i].d;
            #1;
            chk_comb("sweep", tab[i]);
            if (i > 0)
                chk("sweep lag a_q", {30'd0, a_q}, {30'd0, tab[i-1].a});
            tick();
            if (!tab[i].valid || tab[i].multi) exp_cnt++;
            chk_reg("sweep", tab[i].a, tab[i].valid, exp_cnt);
        end
        // sweep adds 12 bad codes on top of the first one
        chk("sweep count", {24'd0, err_cnt}, 32'd13);

        // saturation
        @(negedge clk);
        d = 4'b0000;
        for (int i = 0; i < 300; i++) tick();
        chk("sat", {24'd0, err_cnt}, 32'd255);
        @(negedge clk);
        d = 4'b1111;
        tick();
        chk_reg("sat hold", 2'b11, 1'b1, 255);

        // mid-operation async reset
        #2;
        rst_n = 1'b0;
        #1;
        chk_reg("rst2", 2'b00, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        d = 4'b1111;
        tick();
        chk_reg("pre rst3", 2'b11, 1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reg("rst3 async", 2'b00, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 4'b0100;
        tick();
        chk_reg("release", 2'b10, 1'b1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
